// File: rtl/conv_abuf.sv
// conv_abuf: accumulation buffer that answers the conv address generator's
// accumulate port. It does a lane-masked, saturating read-modify-write of
// MAC results into a BATCH-lane buffer. It also provides a handshaked
// readout port and a bulk-clear engine. Storage is one internal 1R1W
// synchronous RAM with 1-cycle read latency and a per-lane write enable.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   acc_addr/en/new   accumulate op (any en bit set = op); new=1 overwrites
//   acc_data          signed MAC results, lane i at [i*DATA_W +: DATA_W]
//   rd_req/rd_addr    readout request, accepted when rd_req && rd_rdy
//   rd_rdy            readout port free (idle, no accumulate this cycle)
//   rd_vld/rd_data    readout result, one cycle after accept
//   clr / busy        start bulk clear / clear in progress
//
// State table:
//   S_IDLE  | accumulate and readout traffic served
//   S_CLEAR | writing zero to one entry per free write-port cycle
module conv_abuf #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int BATCH  = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_W-1:0]       acc_addr,
  input  logic [BATCH-1:0]        acc_en,
  input  logic                    acc_new,
  input  logic [BATCH*DATA_W-1:0] acc_data,
  input  logic                    rd_req,
  input  logic [ADDR_W-1:0]       rd_addr,
  output logic                    rd_rdy,
  output logic                    rd_vld,
  output logic [BATCH*DATA_W-1:0] rd_data,
  input  logic                    clr,
  output logic                    busy
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int W     = BATCH * DATA_W;

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_cnt;

  logic [W-1:0]        r_mem [DEPTH];
  logic [W-1:0]        r_ram_q;

  logic                r_fwd_hit;
  logic [BATCH-1:0]    r_fwd_mask;
  logic [W-1:0]        r_fwd_data;

  logic                r_s1_vld;
  logic [ADDR_W-1:0]   r_s1_addr;
  logic [BATCH-1:0]    r_s1_en;
  logic                r_s1_new;
  logic [W-1:0]        r_s1_data;

  logic                r_rd_pend;
  logic [W-1:0]        r_rd_hold;

  logic                w_acc_op;
  logic                w_rd_acc;
  logic [ADDR_W-1:0]   w_rd_addr;
  logic [W-1:0]        w_old;
  logic [W-1:0]        w_acc_res;
  logic [DATA_W-1:0]   w_lane_old;
  logic [DATA_W-1:0]   w_lane_in;
  logic [DATA_W:0]     w_sum;
  logic [BATCH-1:0]    w_wr_mask;
  logic [ADDR_W-1:0]   w_wr_addr;
  logic [W-1:0]        w_wr_data;
  logic                w_clr_step;

  // The accumulate port owns the read port; readout only gets it when idle.
  assign w_acc_op  = (|acc_en) && (r_state == S_IDLE) && !rst;
  assign rd_rdy    = (r_state == S_IDLE) && !(|acc_en) && !rst;
  assign w_rd_acc  = rd_req && rd_rdy;
  assign w_rd_addr = w_acc_op ? acc_addr : rd_addr;

  // The RAM returns old data on read-during-write. Lanes written in the
  // read cycle are patched from the captured write.
  always_comb begin
    w_old = r_ram_q;
    for (int i = 0; i < BATCH; i++) begin
      if (r_fwd_hit && r_fwd_mask[i]) begin
        w_old[i*DATA_W +: DATA_W] = r_fwd_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Per-lane saturating add in DATA_W+1 bits. Overflow shows up as
  // disagreement between the top two bits of the sum.
  always_comb begin
    w_acc_res  = '0;
    w_lane_old = '0;
    w_lane_in  = '0;
    w_sum      = '0;
    for (int i = 0; i < BATCH; i++) begin
      w_lane_old = w_old[i*DATA_W +: DATA_W];
      w_lane_in  = r_s1_data[i*DATA_W +: DATA_W];
      w_sum      = {w_lane_old[DATA_W-1], w_lane_old} + {w_lane_in[DATA_W-1], w_lane_in};
      if (r_s1_new) begin
        w_acc_res[i*DATA_W +: DATA_W] = w_lane_in;
      end else if (w_sum[DATA_W] != w_sum[DATA_W-1]) begin
        w_acc_res[i*DATA_W +: DATA_W] = w_sum[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}}
                                                       : {1'b0, {(DATA_W-1){1'b1}}};
      end else begin
        w_acc_res[i*DATA_W +: DATA_W] = w_sum[DATA_W-1:0];
      end
    end
  end

  // A pending accumulate write-back has priority over the clear sweep.
  // When that happens the clear counter stalls.
  always_comb begin
    w_wr_mask  = '0;
    w_wr_addr  = r_cnt;
    w_wr_data  = '0;
    w_clr_step = 1'b0;
    if (!rst) begin
      if (r_s1_vld) begin
        w_wr_mask = r_s1_en;
        w_wr_addr = r_s1_addr;
        w_wr_data = w_acc_res;
      end else if (r_state == S_CLEAR) begin
        w_wr_mask  = '1;
        w_wr_addr  = r_cnt;
        w_clr_step = 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (clr) w_state_nxt = S_CLEAR;
      S_CLEAR: if (w_clr_step && (r_cnt == '1)) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_s1_vld  <= 1'b0;
      r_rd_pend <= 1'b0;
      r_rd_hold <= '0;
      r_fwd_hit <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE) begin
        r_cnt <= '0;
      end else if (w_clr_step) begin
        r_cnt <= r_cnt + 1'b1;
      end
      r_s1_vld  <= w_acc_op;
      r_rd_pend <= w_rd_acc;
      if (r_rd_pend) begin
        r_rd_hold <= w_old;
      end
      r_fwd_hit <= (|w_wr_mask) && (w_wr_addr == w_rd_addr);
    end
  end

  always_ff @(posedge clk) begin
    r_s1_addr  <= acc_addr;
    r_s1_en    <= acc_en;
    r_s1_new   <= acc_new;
    r_s1_data  <= acc_data;
    r_fwd_mask <= w_wr_mask;
    r_fwd_data <= w_wr_data;
  end

  always_ff @(posedge clk) begin
    r_ram_q <= r_mem[w_rd_addr];
    for (int i = 0; i < BATCH; i++) begin
      if (w_wr_mask[i]) begin
        r_mem[w_wr_addr][i*DATA_W +: DATA_W] <= w_wr_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Readout data is live in its valid cycle and then held until the next one.
  assign rd_vld  = r_rd_pend;
  assign rd_data = r_rd_pend ? w_old : r_rd_hold;
  assign busy    = (r_state == S_CLEAR);

endmodule

// File: tb/tb_conv_abuf.sv
module tb_conv_abuf;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int NB = 32;
  localparam int W  = NB * DW;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] acc_addr;
  logic [NB-1:0] acc_en;
  logic          acc_new;
  logic [W-1:0]  acc_data;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          rd_rdy;
  logic          rd_vld;
  logic [W-1:0]  rd_data;
  logic          clr;
  logic          busy;

  int checks = 0;
  int errors = 0;

  // Reference contents: one signed word per lane per entry.
  logic [DW-1:0] mdl [1<<AW][NB];

  conv_abuf #(.ADDR_W(AW), .DATA_W(DW), .BATCH(NB)) dut (
    .clk(clk), .rst(rst),
    .acc_addr(acc_addr), .acc_en(acc_en), .acc_new(acc_new), .acc_data(acc_data),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_rdy(rd_rdy), .rd_vld(rd_vld), .rd_data(rd_data),
    .clr(clr), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    int li;
    li = 0;
    for (int i = NB - 1; i >= 0; i--) if (obs[i*DW +: DW] !== exp[i*DW +: DW]) li = i;
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s lane%0d observed=%h expected=%h", tag, li, obs[li*DW +: DW], exp[li*DW +: DW]);
    end
  endtask

  function automatic logic [W-1:0] mvec(input logic [AW-1:0] a);
    logic [W-1:0] v;
    for (int i = 0; i < NB; i++) v[i*DW +: DW] = mdl[a][i];
    return v;
  endfunction

  task automatic model_zero();
    for (int a = 0; a < (1 << AW); a++)
      for (int i = 0; i < NB; i++) mdl[a][i] = '0;
  endtask

  task automatic model_acc(input logic [AW-1:0] a, input logic [NB-1:0] en,
                           input logic nw, input logic [W-1:0] d);
    longint s;
    for (int i = 0; i < NB; i++) begin
      if (en[i]) begin
        if (nw) s = longint'($signed(d[i*DW +: DW]));
        else    s = longint'($signed(mdl[a][i])) + longint'($signed(d[i*DW +: DW]));
        if (s > 64'sd2147483647)  s = 64'sd2147483647;
        if (s < -64'sd2147483648) s = -64'sd2147483648;
        mdl[a][i] = s[DW-1:0];
      end
    end
  endtask

  // One accumulate op in one cycle; the model applies it in issue order.
  task automatic do_acc(input logic [AW-1:0] a, input logic [NB-1:0] en,
                        input logic nw, input logic [W-1:0] d);
    acc_addr = a; acc_en = en; acc_new = nw; acc_data = d;
    #1;
    chk("rdy_low_in_acc", W'(rd_rdy), W'(0));
    model_acc(a, en, nw, d);
    @(posedge clk);
    #1;
    acc_en = '0;
  endtask

  task automatic do_read(input logic [AW-1:0] a, input bit use_const, input logic [W-1:0] cv);
    logic [W-1:0] exp;
    rd_req = 1'b1; rd_addr = a;
    #1;
    chk("rd_rdy_idle", W'(rd_rdy), W'(1));
    exp = mvec(a);
    tick();
    rd_req = 1'b0;
    chk("rd_vld_after_accept", W'(rd_vld), W'(1));
    chk("rd_data_model", rd_data, exp);
    if (use_const) chk("rd_data_const", rd_data, cv);
    tick();
    chk("rd_vld_drop", W'(rd_vld), W'(0));
    chk("rd_data_hold", rd_data, exp);
  endtask

  task automatic do_clear(input bit with_acc, input logic [AW-1:0] a, input int exp_n);
    logic [W-1:0] d;
    int n;
    for (int i = 0; i < NB; i++) d[i*DW +: DW] = $urandom;
    clr = 1'b1;
    if (with_acc) begin
      acc_addr = a; acc_en = '1; acc_new = 1'b1; acc_data = d;
    end
    tick();
    clr = 1'b0; acc_en = '0;
    n = 0;
    while (busy === 1'b1 && n < 1000) begin
      n++;
      clr = (n == 50);
      tick();
    end
    clr = 1'b0;
    chk("clear_busy_cycles", W'(n), W'(exp_n));
    model_zero();
  endtask

  task automatic rand_cycle(input bit alt, input int k, input int amax);
    bit acc, acc_ok;
    logic [NB-1:0] en;
    logic [W-1:0] d, exp;
    acc = alt ? (k % 2 == 0) : ($urandom_range(0, 1) == 1);
    en = $urandom;
    if (en == '0) en = 1;
    for (int i = 0; i < NB; i++)
      d[i*DW +: DW] = ($urandom_range(0, 3) == 0) ? $urandom : DW'($urandom_range(0, 200)) - 32'd100;
    acc_addr = AW'($urandom_range(0, amax));
    acc_en   = acc ? en : '0;
    acc_new  = ($urandom_range(0, 7) == 0);
    acc_data = d;
    rd_req   = alt ? 1'b1 : 1'($urandom_range(0, 1));
    rd_addr  = AW'($urandom_range(0, amax));
    #1;
    chk("rand_rd_rdy", W'(rd_rdy), W'(!acc));
    acc_ok = rd_req && !acc;
    exp = mvec(rd_addr);
    if (acc) model_acc(acc_addr, acc_en, acc_new, acc_data);
    @(posedge clk);
    #1;
    chk("rand_rd_vld", W'(rd_vld), W'(acc_ok));
    if (acc_ok) chk("rand_rd_data", rd_data, exp);
  endtask

  initial begin
    logic [W-1:0] cv, d;

    rst = 1'b1; acc_addr = '0; acc_en = '0; acc_new = 1'b0; acc_data = '0;
    rd_req = 1'b0; rd_addr = '0; clr = 1'b0;
    #1;
    tick();
    chk("rdy_in_reset", W'(rd_rdy), W'(0));
    tick();
    chk("reset_rd_vld", W'(rd_vld), W'(0));
    chk("reset_rd_data", rd_data, '0);
    chk("reset_busy", W'(busy), W'(0));
    rst = 1'b0;

    // Full clear with an ignored clr mid-sweep, then read entry 5.
    do_clear(1'b0, '0, 256);
    do_read(8'd5, 1'b1, '0);

    // Overwrite then accumulate back-to-back at one address.
    for (int i = 0; i < NB; i++) d[i*DW +: DW] = i;
    do_acc(8'd3, '1, 1'b1, d);
    for (int i = 0; i < NB; i++) d[i*DW +: DW] = 1;
    do_acc(8'd3, '1, 1'b0, d);
    for (int i = 0; i < NB; i++) cv[i*DW +: DW] = i + 1;
    do_read(8'd3, 1'b1, cv);

    // Four masked accumulates after a clear.
    do_clear(1'b0, '0, 256);
    for (int i = 0; i < NB; i++) d[i*DW +: DW] = 10;
    for (int k = 0; k < 4; k++) do_acc(8'd7, 32'h0000_FFFF, 1'b0, d);
    for (int i = 0; i < NB; i++) cv[i*DW +: DW] = (i < 16) ? 40 : 0;
    do_read(8'd7, 1'b1, cv);

    // Saturation at both ends.
    d = '0; d[0 +: DW] = 32'h7FFF_FFF0; d[DW +: DW] = 32'h8000_0010;
    do_acc(8'd9, 32'h3, 1'b1, d);
    d = '0; d[0 +: DW] = 32'h0000_0020; d[DW +: DW] = 32'hFFFF_FFE0;
    do_acc(8'd9, 32'h3, 1'b0, d);
    cv = '0; cv[0 +: DW] = 32'h7FFF_FFFF; cv[DW +: DW] = 32'h8000_0000;
    do_read(8'd9, 1'b1, cv);

    // rd_req held while accumulates pulse every other cycle.
    for (int k = 0; k < 40; k++) rand_cycle(1'b1, k, 3);
    acc_en = '0; rd_req = 1'b0;
    tick();

    // Mixed random traffic over a wider address range.
    for (int k = 0; k < 200; k++) rand_cycle(1'b0, k, 15);
    acc_en = '0; rd_req = 1'b0;
    tick();
    do_read(8'd2, 1'b0, '0);

    // clr together with an accumulate: one stall cycle, and the entry ends up zero.
    do_clear(1'b1, 8'd11, 257);
    do_read(8'd11, 1'b1, '0);

    // Reset in the middle of a clear at counter 100.
    clr = 1'b1;
    tick();
    clr = 1'b0;
    repeat (100) tick();
    chk("busy_mid_clear", W'(busy), W'(1));
    rst = 1'b1;
    #1;
    chk("rdy_in_reset_mid_clear", W'(rd_rdy), W'(0));
    tick();
    rst = 1'b0;
    chk("busy_after_abort", W'(busy), W'(0));
    chk("rd_vld_after_abort", W'(rd_vld), W'(0));
    chk("rd_data_after_abort", rd_data, '0);
    do_clear(1'b0, '0, 256);
    do_read(AW'($urandom_range(0, 255)), 1'b1, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_abuf.md
Name: conv_abuf

Overview:
- Accumulation buffer responder for the PE conv address generator's accumulate port (abuf_addr / abuf_acc_en / abuf_acc_new).
- Performs lane-masked, saturating read-modify-write accumulation of MAC array results into a BATCH-lane buffer. No backpressure on this port.
- Provides a handshaked readout port for result drain and a bulk-clear engine.
- Storage: one 1R1W synchronous RAM, 1-cycle read latency, per-lane write enable. The RAM is inside this block.

Parameters:
ADDR_W, 8, buffer address width; depth = 2^ADDR_W entries
DATA_W, 32, signed accumulator width per lane
BATCH, 32, lanes per entry

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
acc_addr  in  ADDR_W  accumulate address
acc_en  in  BATCH  per-lane accumulate enable; any bit set = accumulate op
acc_new  in  1  1: enabled lanes overwrite (old value treated as 0)
acc_data  in  BATCH*DATA_W  signed MAC results, lane i at [i*DATA_W +: DATA_W]
rd_req  in  1  readout request
rd_addr  in  ADDR_W  readout address
rd_rdy  out  1  readout accepted when rd_req && rd_rdy
rd_vld  out  1  readout data valid
rd_data  out  BATCH*DATA_W  readout entry
clr  in  1  start bulk clear (pulse)
busy  out  1  clear in progress

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: rd_vld=0, rd_data=0, busy=0, rd_rdy=0 during the reset cycle. FSM=IDLE; S1 valid cleared.
- Reset does not clear RAM contents. Reset mid-clear aborts the clear; contents become undefined and software must clear again.
- Accumulate op accepted at cycle T (|acc_en):
  - RAM read of acc_addr is issued at T.
  - At T+1, stage S1 holds addr/en/new/data plus the RAM output.
  - Per lane i with en[i]: new = acc_new ? data[i] : sat(old[i] + data[i]).
  - Write at the end of T+1, lane-masked by en. Lanes with en=0 are untouched.
  - Sustained rate: 1 op/cycle.
- Saturation: signed add in DATA_W+1 bits, clamped to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- Forwarding (read-during-write, RAM returns old data):
  - Applies when a read (acc or readout) is issued in the same cycle as a write to the same address.
  - For the next cycle, lanes enabled in that write take the written value; the other lanes take the RAM output.
  - Required so back-to-back accumulates to one address sum correctly.
- Readout:
  - rd_rdy = (FSM==IDLE) && !(|acc_en) && !rst; the accumulate port owns the read port.
  - On accept at T: rd_vld=1 and rd_data valid at T+1, with forwarding applied. Otherwise rd_vld=0 and rd_data holds its last value.
  - Readout does not modify contents.
- Clear FSM:
  - IDLE: clr && !busy -> CLEAR, counter=0, busy=1 from the next cycle.
  - CLEAR: each cycle writes 0 to all lanes at counter, counter++.
  - If an S1 accumulate write is pending that cycle, it takes the write port and the counter stalls.
  - After entry 2^ADDR_W-1 is written -> IDLE, busy=0 the next cycle. Total 2^ADDR_W cycles with no stalls.
  - clr while busy is ignored.
  - Accumulate ops arriving during CLEAR are dropped (protocol violation; upstream waits on busy).
- Simultaneous clr and accumulate in IDLE: the accumulate completes, then the clear overwrites its entry.
- Addresses wrap naturally at ADDR_W; no bounds checks.

Test Plan:
- Clear 256 entries, then readout addr 5 -> busy high for exactly 256 cycles; rd_data all zero, rd_vld one cycle after accept.
- acc_new=1, addr 3, all lanes data=i; next cycle acc_new=0, addr 3, data=1 -> readout addr 3 lane i = i+1 (exercises forwarding).
- Four consecutive accumulates to addr 7, acc_en=32'h0000_FFFF, data=10, after a clear -> lanes 0-15 = 40, lanes 16-31 = 0.
- Lane 0 preloaded 0x7FFF_FFF0, accumulate +0x20 -> 0x7FFF_FFFF. Lane 1 preloaded 0x8000_0010, accumulate -0x20 -> 0x8000_0000.
- rd_req held high while acc_en pulses every other cycle -> rd_rdy low exactly in acc cycles; each accepted read returns the up-to-date value.
- rst asserted mid-clear at counter 100 -> busy=0 and rd_vld=0 the next cycle; a new clr is accepted and completes in 256 cycles.
